// File: rtl/pwm_bank_if.sv
// Frame bus carrying per-channel duty targets and soft-ramp enables into pwm_bank.
interface pwm_bank_if #(
   parameter int unsigned N_CH   = 10,
   parameter int unsigned DUTY_W = 8
);
   logic                     frame_valid;
   logic [N_CH*DUTY_W-1:0]   frame_data;
   logic [N_CH-1:0]          ramp_en;

   modport master (output frame_valid, frame_data, ramp_en);
   modport slave  (input  frame_valid, frame_data, ramp_en);
endinterface

// File: rtl/pwm_bank.sv
// N-channel PWM bank: duty targets arrive as one packed frame, current duty
// changes only at period boundaries (optionally ramped), outputs are registered.
module pwm_bank #(
   parameter int unsigned N_CH      = 10,
   parameter int unsigned DUTY_W    = 8,
   parameter int unsigned PRESCALE  = 2,
   parameter int unsigned RAMP_STEP = 1
) (
   input  logic            clk50M,
   input  logic            rst,
   pwm_bank_if.slave       frame,
   output logic [N_CH-1:0] pwm_out,
   output logic            period_tick,
   output logic            busy
);
   localparam int unsigned MAX  = (1 << DUTY_W) - 1;
   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(MAX - 1);
   localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(RAMP_STEP);

   logic [PS_W-1:0]                psc, psc_next;
   logic [DUTY_W-1:0]              cnt, cnt_next;
   logic                           step_c, boundary_c;
   logic [N_CH-1:0][DUTY_W-1:0]    target, target_next;
   logic [N_CH-1:0][DUTY_W-1:0]    cur, cur_next;
   logic [N_CH-1:0]                pwm_next;
   logic                           busy_next;

   // Prescaler and period counter; a boundary is the step that wraps the counter.
   always_comb begin
      step_c     = (psc == PS_LAST);
      psc_next   = step_c ? '0 : psc + PS_W'(1);
      boundary_c = step_c && (cnt == CNT_LAST);
      cnt_next   = cnt;
      if (step_c) begin
         cnt_next = boundary_c ? '0 : cnt + DUTY_W'(1);
      end
   end

   // Per-channel target capture, boundary duty update (ramped or direct) and output compare.
   always_comb begin
      cur_next    = cur;
      target_next = target;
      pwm_next    = '0;
      busy_next   = 1'b0;
      for (int k = 0; k < int'(N_CH); k++) begin
         if (frame.frame_valid) begin
            target_next[k] = frame.frame_data[k*DUTY_W +: DUTY_W];
         end
         // The boundary update always uses the target held before this edge.
         if (boundary_c) begin
            if (!frame.ramp_en[k] || (target[k] == cur[k])) begin
               cur_next[k] = target[k];
            end else if (target[k] > cur[k]) begin
               cur_next[k] = ((target[k] - cur[k]) <= STEP) ? target[k] : cur[k] + STEP;
            end else begin
               cur_next[k] = ((cur[k] - target[k]) <= STEP) ? target[k] : cur[k] - STEP;
            end
         end
         pwm_next[k] = (cur[k] > cnt_next);
         if (cur_next[k] != target_next[k]) begin
            busy_next = 1'b1;
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         psc         <= '0;
         cnt         <= '0;
         target      <= '0;
         cur         <= '0;
         pwm_out     <= '0;
         period_tick <= 1'b0;
         busy        <= 1'b0;
      end else begin
         psc         <= psc_next;
         cnt         <= cnt_next;
         target      <= target_next;
         cur         <= cur_next;
         pwm_out     <= pwm_next;
         period_tick <= boundary_c;
         busy        <= busy_next;
      end
   end
endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: a 3-channel instance checked every cycle against an
// arithmetic model, plus a 1-channel PRESCALE=1 instance for fast-count behaviour.
module tb_pwm_bank;
   localparam int unsigned NA    = 3;
   localparam int unsigned W     = 8;
   localparam int unsigned PA    = 2;
   localparam int          SA    = 50;
   localparam int          MAXV  = 255;
   localparam int          PER_A = MAXV * int'(PA);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pwm_bank_if #(.N_CH(NA), .DUTY_W(W)) bus_a ();
   pwm_bank_if #(.N_CH(1),  .DUTY_W(W)) bus_b ();

   logic [NA-1:0] pwm_a;
   logic          tick_a, busy_a;
   logic [0:0]    pwm_b;
   logic          tick_b, busy_b;

   pwm_bank #(.N_CH(NA), .DUTY_W(W), .PRESCALE(PA), .RAMP_STEP(SA)) dut_a (
      .clk50M(clk), .rst(rst), .frame(bus_a.slave),
      .pwm_out(pwm_a), .period_tick(tick_a), .busy(busy_a));

   pwm_bank #(.N_CH(1), .DUTY_W(W), .PRESCALE(1), .RAMP_STEP(1)) dut_b (
      .clk50M(clk), .rst(rst), .frame(bus_b.slave),
      .pwm_out(pwm_b), .period_tick(tick_b), .busy(busy_b));

   int total = 0;
   int bad   = 0;

   // Reference model state for dut_a: edges since reset release, duties, targets.
   int          m_e;
   int          nb;
   int          gidx = 0;
   int          rel  = 0;
   int          m_cur [NA];
   int          m_tgt [NA];
   logic [NA-1:0] ex_pwm;
   logic        ex_tick, ex_busy;
   int          meas [NA];

   typedef struct {
      int d  [NA];
      int hi [NA];
   } vec_t;
   vec_t tbl [3];

   int exp_up   [4];
   int exp_down [4];
   int i1, i2, hb, hz, zb;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock edge: advance the model from the inputs that were applied, then compare.
   task automatic tick();
      int cn;
      bit bnd;
      @(posedge clk);
      gidx++;
      if (rst) begin
         m_e = 0;
         nb  = 0;
         for (int k = 0; k < int'(NA); k++) begin
            m_cur[k] = 0;
            m_tgt[k] = 0;
         end
         ex_pwm  = '0;
         ex_tick = 1'b0;
         ex_busy = 1'b0;
      end else begin
         m_e++;
         bnd = ((m_e % PER_A) == 0);
         cn  = (m_e / int'(PA)) % MAXV;
         for (int k = 0; k < int'(NA); k++) ex_pwm[k] = (m_cur[k] > cn);
         if (bnd) begin
            nb++;
            for (int k = 0; k < int'(NA); k++) begin
               if (!bus_a.ramp_en[k]) m_cur[k] = m_tgt[k];
               else if (m_tgt[k] > m_cur[k])
                  m_cur[k] = (m_cur[k] + SA > m_tgt[k]) ? m_tgt[k] : m_cur[k] + SA;
               else
                  m_cur[k] = (m_cur[k] - SA < m_tgt[k]) ? m_tgt[k] : m_cur[k] - SA;
            end
         end
         if (bus_a.frame_valid)
            for (int k = 0; k < int'(NA); k++) m_tgt[k] = int'(bus_a.frame_data[k*W +: W]);
         ex_tick = bnd;
         ex_busy = 1'b0;
         for (int k = 0; k < int'(NA); k++) if (m_cur[k] != m_tgt[k]) ex_busy = 1'b1;
      end
      #1;
      check("pwm_out", int'(pwm_a), int'(ex_pwm));
      check("period_tick", int'(tick_a), int'(ex_tick));
      check("busy", int'(busy_a), int'(ex_busy));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus_a.frame_valid = 1'b0;
      bus_b.frame_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      rel = gidx;
   endtask

   task automatic load(input int d0, input int d1, input int d2, input logic [NA-1:0] ramp);
      bus_a.ramp_en     = ramp;
      bus_a.frame_data  = {8'(d2), 8'(d1), 8'(d0)};
      bus_a.frame_valid = 1'b1;
      tick();
      bus_a.frame_valid = 1'b0;
   endtask

   task automatic wait_bnd(input int n);
      int start;
      start = nb;
      for (int g = 0; g < PER_A * (n + 1) + 10 && nb < start + n; g++) tick();
      if (nb - start < n) check("wait_boundary_timeout", nb - start, n);
   endtask

   // High clocks per channel over one full period following the current edge.
   task automatic measure();
      for (int k = 0; k < int'(NA); k++) meas[k] = 0;
      for (int i = 0; i < PER_A; i++) begin
         tick();
         for (int k = 0; k < int'(NA); k++) if (pwm_a[k]) meas[k]++;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus_a.frame_valid = 1'b0;
      bus_a.frame_data  = '0;
      bus_a.ramp_en     = '0;
      bus_b.frame_valid = 1'b0;
      bus_b.frame_data  = '0;
      bus_b.ramp_en     = '0;

      tbl[0].d = '{0, 128, 255};   tbl[0].hi = '{0, 256, 510};
      tbl[1].d = '{1, 254, 10};    tbl[1].hi = '{2, 508, 20};
      tbl[2].d = '{255, 0, 77};    tbl[2].hi = '{510, 0, 154};
      exp_up   = '{100, 200, 300, 400};
      exp_down = '{300, 200, 100, 60};

      // Reset state.
      do_reset();
      check("reset_pwm", int'(pwm_a), 0);
      check("reset_tick", int'(tick_a), 0);
      check("reset_busy", int'(busy_a), 0);

      // Direct (unramped) loads from a table.
      for (int i = 0; i < 3; i++) begin
         load(tbl[i].d[0], tbl[i].d[1], tbl[i].d[2], 3'b000);
         wait_bnd(1);
         check("busy_after_first_boundary", int'(busy_a), 0);
         wait_bnd(1);
         measure();
         for (int k = 0; k < int'(NA); k++) check("table_high_clocks", meas[k], tbl[i].hi[k]);
      end

      // Ramp up 0 -> 200 in steps of 50, then down 200 -> 30 with clamp.
      do_reset();
      load(0, 200, 0, 3'b010);
      wait_bnd(1);
      for (int j = 0; j < 4; j++) begin
         check("ramp_up_busy", int'(busy_a), (j < 3) ? 1 : 0);
         measure();
         check("ramp_up_high", meas[1], exp_up[j]);
      end
      load(0, 30, 0, 3'b010);
      wait_bnd(1);
      for (int j = 0; j < 4; j++) begin
         check("ramp_down_busy", int'(busy_a), (j < 3) ? 1 : 0);
         measure();
         check("ramp_down_high", meas[1], exp_down[j]);
      end

      // Frame arriving on the boundary edge takes effect one period later.
      do_reset();
      load(10, 0, 0, 3'b000);
      wait_bnd(2);
      for (int g = 0; g < PER_A && ((m_e + 1) % PER_A) != 0; g++) tick();
      load(90, 0, 0, 3'b000);
      check("coincident_tick", int'(tick_a), 1);
      measure();
      check("coincident_old_duty", meas[0], 20);
      measure();
      check("coincident_new_duty", meas[0], 180);

      // Asynchronous reset in the middle of a high phase of a ramp.
      do_reset();
      load(0, 200, 0, 3'b010);
      wait_bnd(2);
      for (int g = 0; g < 5; g++) tick();
      check("pre_reset_high", int'(pwm_a[1]), 1);
      #1;
      rst = 1'b1;
      #1;
      check("async_reset_pwm", int'(pwm_a), 0);
      check("async_reset_busy", int'(busy_a), 0);
      tick();
      tick();
      rst = 1'b0;
      rel = gidx;
      hz = 0;
      zb = 0;
      for (int g = 0; g < 600; g++) begin
         tick();
         if (pwm_a != '0) hz++;
         if (busy_a) zb++;
      end
      check("post_reset_pwm_highs", hz, 0);
      check("post_reset_busy_cycles", zb, 0);

      // PRESCALE=1 instance: target 1 gives one high clock per 255-clock period.
      do_reset();
      bus_b.ramp_en     = 1'b0;
      bus_b.frame_data  = 8'd1;
      bus_b.frame_valid = 1'b1;
      tick();
      bus_b.frame_valid = 1'b0;
      i1 = -1;
      i2 = -1;
      for (int g = 0; g < 1000 && i2 < 0; g++) begin
         tick();
         if (tick_b) begin
            if (i1 < 0) i1 = gidx;
            else        i2 = gidx;
         end
      end
      check("b_first_tick_edge", i1 - rel, 255);
      check("b_tick_gap", i2 - i1, 255);
      hb = 0;
      for (int g = 0; g < 255; g++) begin
         tick();
         if (pwm_b[0]) hb++;
      end
      check("b_high_clocks", hb, 1);
      check("b_busy", int'(busy_b), 0);

      // Randomized frames, ramp-enable changes and occasional resets.
      do_reset();
      for (int c = 0; c < 12000; c++) begin
         if ($urandom_range(0, 5999) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 399) == 0) begin
            load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
         end else begin
            if ($urandom_range(0, 1499) == 0) bus_a.ramp_en = 3'($urandom_range(0, 7));
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
